// File: rtl/dist_ram_sdp.sv
// Simple-dual-port LUT RAM (one write port, one read port, one clock) with a built-in clear sweep.
// Latency: read is combinational when OUT_REG=0 and one cycle (read-first) when OUT_REG=1; writes land at the edge.
// Backpressure: none; user writes issued while BUSY=1 are dropped and flagged on WE_ERR the following cycle.
module dist_ram_sdp #(
    parameter int                              DATA_W    = 8,
    parameter int                              ADDR_W    = 6,
    parameter logic [DATA_W*(2**ADDR_W)-1:0]   INIT      = '0,
    parameter int                              OUT_REG   = 0,
    parameter logic [DATA_W-1:0]               CLR_VALUE = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    output logic              BUSY,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] D,
    output logic              WE_ERR,
    input  logic [ADDR_W-1:0] RA,
    output logic [DATA_W-1:0] O
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cnt_nxt;

    // Single internal write port shared by the user and the sweep; they never
    // compete because user writes are only honoured in IDLE.
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    // Flat storage so the power-up image maps directly onto INIT.
    logic [DATA_W*DEPTH-1:0] mem = INIT;
    logic [DATA_W-1:0]       rd_dat;

    // State register and sweep counter; reset aborts any sweep in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and write-port arbitration between user and sweep.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_wa    = WA;
        mem_wd    = D;
        case (state)
            IDLE: begin
                // The write in the CLR cycle still goes through: BUSY is low.
                mem_we = WE;
                if (CLR) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                mem_we = 1'b1;
                mem_wa = cnt;
                mem_wd = CLR_VALUE;
                // Explicit terminal compare rather than relying on wrap-around.
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Memory write; nothing is written in a reset cycle, but content survives reset.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem[int'(mem_wa)*DATA_W +: DATA_W] <= mem_wd;
        end
    end

    // Dropped-write flag, one cycle after the offending write attempt.
    always_ff @(posedge CLK) begin
        if (RST) begin
            WE_ERR <= 1'b0;
        end else begin
            WE_ERR <= (state == SWEEP) && WE;
        end
    end

    assign BUSY   = (state == SWEEP);
    assign rd_dat = mem[int'(RA)*DATA_W +: DATA_W];

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] o_q;

            // Registered read samples the array before this edge's write (read-first).
            always_ff @(posedge CLK) begin
                if (RST) begin
                    o_q <= '0;
                end else begin
                    o_q <= rd_dat;
                end
            end

            assign O = o_q;
        end else begin : g_oasync
            assign O = rd_dat;
        end
    endgenerate

endmodule

// File: tb/tb_dist_ram_sdp.sv
// Self-checking bench for dist_ram_sdp: async and registered 16x8 instances share stimulus,
// a 256x1 instance covers the extreme geometry. Reference model tracks memory as an array
// and the sweep as a start-edge timestamp.
module tb_dist_ram_sdp;

    typedef struct {
        logic [3:0] ra;
        logic [7:0] exp;
    } rd_vec_t;

    function automatic logic [127:0] mk_init_a();
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(k);
        return r;
    endfunction

    localparam logic [127:0] INIT_A = mk_init_a();
    localparam logic [255:0] INIT_W = {128{2'b01}};

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared stimulus for the two 16x8 instances.
    logic       rst, clr, we;
    logic [3:0] wa, ra;
    logic [7:0] d;
    logic       busy_a, busy_r, err_a, err_r;
    logic [7:0] o_a, o_r;

    // Stimulus for the 256x1 instance.
    logic       w_rst, w_clr, w_we;
    logic [7:0] w_wa, w_ra;
    logic [0:0] w_d, w_o;
    logic       w_busy, w_err;

    dist_ram_sdp #(.DATA_W(8), .ADDR_W(4), .INIT(INIT_A), .OUT_REG(0), .CLR_VALUE(8'hFF)) u_async (
        .CLK(CLK), .RST(rst), .CLR(clr), .BUSY(busy_a), .WE(we), .WA(wa), .D(d),
        .WE_ERR(err_a), .RA(ra), .O(o_a)
    );

    dist_ram_sdp #(.DATA_W(8), .ADDR_W(4), .INIT(INIT_A), .OUT_REG(1), .CLR_VALUE(8'hFF)) u_reg (
        .CLK(CLK), .RST(rst), .CLR(clr), .BUSY(busy_r), .WE(we), .WA(wa), .D(d),
        .WE_ERR(err_r), .RA(ra), .O(o_r)
    );

    dist_ram_sdp #(.DATA_W(1), .ADDR_W(8), .INIT(INIT_W), .OUT_REG(0), .CLR_VALUE(1'b0)) u_wide (
        .CLK(CLK), .RST(w_rst), .CLR(w_clr), .BUSY(w_busy), .WE(w_we), .WA(w_wa), .D(w_d),
        .WE_ERR(w_err), .RA(w_ra), .O(w_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model for the 16x8 pair.
    logic [7:0] mm [16];
    int         cyc      = 0;   // edges elapsed
    int         sw_start = 0;   // edge index at which CLR was accepted
    bit         sw_on    = 1'b0;
    bit         exp_err  = 1'b0;
    logic [7:0] exp_or   = 8'h00;

    rd_vec_t vec [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Busy covers the 16 cycles following the CLR edge.
    function automatic bit busy_now();
        return sw_on && (cyc - sw_start >= 1) && (cyc - sw_start <= 16);
    endfunction

    task automatic model_edge();
        bit b;
        b      = busy_now();
        exp_or = rst ? 8'h00 : mm[ra];
        if (rst) begin
            sw_on   = 1'b0;
            exp_err = 1'b0;
        end else if (b) begin
            mm[cyc - sw_start - 1] = 8'hFF;
            exp_err = we;
        end else begin
            exp_err = 1'b0;
            if (we) mm[wa] = d;
            if (clr) begin
                sw_on    = 1'b1;
                sw_start = cyc;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("busy_a", busy_a, busy_now());
        chk("busy_r", busy_r, busy_now());
        chk("we_err_a", err_a, exp_err);
        chk("we_err_r", err_r, exp_err);
        chk("o_reg", o_r, exp_or);
        chk("o_async", o_a, mm[ra]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int err_cnt;

        for (int k = 0; k < 16; k++) begin
            mm[k]      = 8'(k);
            vec[k].ra  = 4'(k);
            vec[k].exp = 8'(k);
        end

        rst = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; ra = '0; d = '0;
        w_rst = 1'b1; w_clr = 1'b0; w_we = 1'b0; w_wa = '0; w_ra = '0; w_d = '0;
        tick();
        tick();
        chk("reset_o_reg", o_r, 8'h00);
        rst = 1'b0; w_rst = 1'b0;

        // Power-up image through the async port.
        for (int i = 0; i < 16; i++) begin
            ra = vec[i].ra;
            tick();
            chk("init_read", o_a, vec[i].exp);
        end

        // Async read: old data before the edge, new data after.
        ra = 4'd5; wa = 4'd5; d = 8'hA5; we = 1'b1;
        #1;
        chk("async_pre_edge", o_a, 8'h05);
        tick();
        chk("async_post_edge", o_a, 8'hA5);
        we = 1'b0;

        // Registered read-first collision.
        ra = 4'd3; wa = 4'd3; d = 8'h3C; we = 1'b1;
        tick();
        chk("reg_read_first", o_r, 8'h03);
        we = 1'b0;
        tick();
        chk("reg_new_data", o_r, 8'h3C);
        rst = 1'b1;
        tick();
        chk("reg_reset", o_r, 8'h00);
        rst = 1'b0;

        // CLR with a same-cycle user write; write lands before the sweep overwrites it.
        clr = 1'b1; we = 1'b1; wa = 4'd2; d = 8'h11; ra = 4'd2;
        tick();
        chk("clr_cycle_write", o_a, 8'h11);
        clr = 1'b0; we = 1'b0;

        busy_cnt = 0;
        err_cnt  = 0;
        for (int i = 0; i < 40 && busy_a; i++) begin
            busy_cnt++;
            we  = (i >= 4 && i < 7);
            wa  = 4'(i + 8);
            d   = 8'h5A;
            clr = (i == 9);
            tick();
            if (err_a) err_cnt++;
        end
        we = 1'b0; clr = 1'b0;
        chk("sweep_busy_len", 64'(busy_cnt), 64'd16);
        chk("sweep_we_err_cnt", 64'(err_cnt), 64'd3);
        for (int k = 0; k < 16; k++) begin
            ra = 4'(k);
            tick();
            chk("swept_value", o_a, 8'hFF);
        end

        // Reset in the middle of a sweep.
        for (int k = 0; k < 16; k++) begin
            we = 1'b1; wa = 4'(k); d = 8'(8'h40 + k);
            tick();
        end
        we = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy_a, 1'b0);
        for (int k = 0; k < 16; k++) begin
            ra = 4'(k);
            tick();
            chk("abort_content", o_a, (k < 6) ? 8'hFF : 8'(8'h40 + k));
        end
        we = 1'b1; wa = 4'd9; d = 8'h77; ra = 4'd9;
        tick();
        we = 1'b0;
        chk("post_abort_err", err_a, 1'b0);
        chk("post_abort_write", o_a, 8'h77);

        // 256x1: image readback, full sweep length, cleared content.
        for (int k = 0; k < 256; k++) begin
            w_ra = 8'(k);
            tick();
            chk("wide_init", w_o, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        w_clr = 1'b1;
        tick();
        w_clr = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 300 && w_busy; i++) begin
            busy_cnt++;
            tick();
        end
        chk("wide_busy_len", 64'(busy_cnt), 64'd256);
        for (int k = 0; k < 256; k += 7) begin
            w_ra = 8'(k);
            tick();
            chk("wide_cleared", w_o, 1'b0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom % 60) == 0;
            clr = ($urandom % 40) == 0;
            we  = $urandom % 2;
            wa  = 4'($urandom);
            d   = 8'($urandom);
            ra  = 4'($urandom);
            #1;
            chk("rand_async_pre", o_a, mm[ra]);
            tick();
        end
        rst = 1'b0; clr = 1'b0; we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dist_ram_sdp.md
Name: dist_ram_sdp

Overview:
Parametrised simple-dual-port distributed (LUT) RAM: one write port and one independent read port on a single clock.
- Generalises the fixed 256x1 single-port select RAM to DATA_W x 2^ADDR_W with separate write and read addresses.
- Optional registered read output.
- Built-in clear sequencer that sweeps the whole array to a programmable value.
- Used for register files, small lookup tables and FIFO storage in LUT-RAM-mapped logic.

Parameters:
- DATA_W, 8, data width in bits (1..64).
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W (2..1024).
- INIT, all zeros, DATA_W*DEPTH-bit power-up image; word k = INIT[k*DATA_W +: DATA_W].
- OUT_REG, 0, 0 = asynchronous read (latency 0); 1 = registered read (latency 1).
- CLR_VALUE, all zeros, DATA_W-bit word written to every location by the clear sweep.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- CLR  in  1  start clear sweep; single-cycle pulse or level; sampled only in IDLE.
- BUSY  out  1  clear sweep in progress.
- WE  in  1  user write enable.
- WA  in  ADDR_W  write address.
- D  in  DATA_W  write data.
- WE_ERR  out  1  one-cycle pulse: a user write was dropped because BUSY=1.
- RA  in  ADDR_W  read address.
- O  out  DATA_W  read data.

Behaviour:
- Memory array:
  - Power-up content is INIT.
  - Not affected by RST; only writes and the clear sweep change it.
- Reset (RST=1 at an edge):
  - FSM -> IDLE; sweep counter -> 0.
  - BUSY=0 and WE_ERR=0 from the next cycle.
  - If OUT_REG=1, the O register -> 0.
  - A user write in the reset cycle is not performed.
- FSM, two states:
  - IDLE: CLR=1 -> SWEEP with counter=0. A user write in that same cycle is performed, since BUSY is still 0.
  - SWEEP: each cycle writes CLR_VALUE to mem[counter]; counter increments. When counter = DEPTH-1, the write happens and FSM -> IDLE.
  - BUSY=1 exactly DEPTH cycles, starting the cycle after CLR is sampled.
  - CLR while in SWEEP is ignored; there is no restart.
- Writes:
  - In IDLE: WE=1 writes D to mem[WA] at the edge.
  - In SWEEP: WE=1 is dropped and WE_ERR=1 in the following cycle; WE_ERR stays high on consecutive dropped writes.
- Reset mid-sweep:
  - The sweep is aborted. Locations already swept keep CLR_VALUE; the rest keep prior content.
  - BUSY=0 the next cycle.
- Read, OUT_REG=0:
  - O = mem[RA], combinational.
  - If RA == write address in the write cycle, O shows old data until the edge, new data after.
- Read, OUT_REG=1:
  - Read-first: O(n+1) = mem[RA(n)] as it was before the write at edge n.
  - Applies equally to sweep writes.
- Reads are always allowed, including during SWEEP, and return current content.
- Addresses are ADDR_W bits wide with no out-of-range case. The counter compares against DEPTH-1 and does not rely on wrap-around.

Test Plan:
1. Async read, OUT_REG=0, DATA_W=8, ADDR_W=4, INIT word k = k:
   - Read RA=0..15 with no writes -> O=0x00..0x0F.
   - Write WA=5, D=0xA5 -> O with RA=5 shows 0x05 before the edge and 0xA5 after.
2. Registered read-first, OUT_REG=1:
   - Same cycle: WE=1, WA=RA=3, D=0x3C with old content 0x03 -> O=0x03 next cycle, 0x3C the cycle after.
   - RST=1 -> O=0x00 next cycle.
3. Clear sweep, DEPTH=16, CLR_VALUE=0xFF:
   - Pulse CLR -> BUSY high for exactly 16 cycles, then low.
   - All 16 reads return 0xFF.
   - A second CLR pulse during BUSY does not extend the sweep.
4. Write collision:
   - Write WA=2, D=0x11 in the CLR cycle -> accepted, then overwritten with 0xFF by the sweep.
   - WE=1 for 3 cycles mid-sweep -> WE_ERR high for those 3 cycles (one cycle delayed); mem unaffected except sweep values.
5. Reset mid-sweep:
   - Assert RST at sweep cycle 6 -> BUSY=0 next cycle.
   - Addresses 0..5 = CLR_VALUE; 6..15 retain prior data.
   - A user write afterwards succeeds with WE_ERR=0.
6. Extremes:
   - DATA_W=1, ADDR_W=8, INIT alternating 1/0 -> read pattern matches INIT.
   - Full sweep completes in 256 cycles.
